// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N_REQ byte-stream requesters.
// Round-robin grant with packet locking (held until 'last') and an optional
// burst cap. tx_en, ack and tx_data are all registered, so they appear
// together in the cycle after the SEND decision. That cycle is the first
// HOLD cycle, and data_in is already valid while en is high.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MAX_BURST   = 16,
  parameter int RDY_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   last,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  input  logic               tx_rdy,
  output logic               timeout_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = (RDY_TIMEOUT > 0) ? $clog2(RDY_TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);
  localparam logic [TW-1:0] TMO_LAST    = TW'(RDY_TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX    = PW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t                      state, state_nxt;
  logic [N_REQ-1:0][7:0]       data_v;
  logic [PW-1:0]               ptr, owner, pick_idx, cand, owner_inc;
  logic                        pick_found;
  logic [BW-1:0]               burst_cnt;
  logic [TW-1:0]               tmo_cnt;
  logic                        last_flag;
  logic                        burst_done;
  logic                        do_grant, do_send, do_release, do_tmo;

  assign data_v     = data;
  assign busy       = (state != IDLE);
  assign owner_inc  = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  assign burst_done = (MAX_BURST != 0) && (burst_cnt == BURST_LIMIT);

  // Round-robin pick: first asserted req at or after ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = PW'((int'(ptr) + i) % N_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and one-cycle control strobes for the datapath.
  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_send    = 1'b0;
    do_release = 1'b0;
    do_tmo     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          do_grant  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (!req[owner]) begin
          do_release = 1'b1;
          state_nxt  = IDLE;
        end else if (tx_rdy) begin
          do_send   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // rdy may still read high in the en cycle; only a fall proves acceptance
        if (!tx_rdy) begin
          if (last_flag || burst_done) begin
            do_release = 1'b1;
            state_nxt  = IDLE;
          end else begin
            state_nxt = SEND;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          do_tmo     = 1'b1;
          do_release = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ownership: grant vector, owner index and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
    end else if (do_grant) begin
      grant <= N_REQ'(1) << pick_idx;
      owner <= pick_idx;
    end else if (do_release) begin
      grant <= '0;
      ptr   <= owner_inc;
    end
  end

  // Byte launch: en, ack and data together, plus the packet bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_en     <= 1'b0;
      ack       <= '0;
      tx_data   <= 8'h00;
      last_flag <= 1'b0;
      burst_cnt <= '0;
    end else begin
      tx_en <= do_send;
      ack   <= do_send ? grant : '0;
      if (do_send) begin
        tx_data   <= data_v[owner];
        last_flag <= last[owner];
      end
      if (do_grant)     burst_cnt <= '0;
      else if (do_send) burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Watchdog on rdy staying high in HOLD; error flag is sticky until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (do_send)
        tmo_cnt <= '0;
      else if (state == HOLD && tx_rdy && !do_tmo)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (do_tmo) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a uart_tx model, and a
// packet-level scheduler model that predicts the order of transmitted bytes.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int MB = 2;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, last, ack, grant;
  logic [8*N-1:0] data;
  logic           busy, tx_en, tx_rdy, timeout_err;
  logic [7:0]     tx_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .RDY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
    .ack(ack), .grant(grant), .busy(busy), .tx_en(tx_en),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .timeout_err(timeout_err)
  );

  int tests = 0;
  int fails = 0;

  // requester byte queues: bit 8 = last marker
  logic [8:0] rbuf [N][32];
  int         rhead [N];
  int         rtail [N];
  logic [N-1:0] pp;

  // model packet lists and predicted transmit order {owner[2:0], byte}
  logic [8:0]  mp [N][32];
  int          mlen [N];
  int          model_ptr;
  logic [10:0] expq [$];
  bit          sb_on;

  // uart model and observation state
  int         umode;
  int         ucnt;
  logic       en_s;
  int         cyc = 0;
  int         n_en = 0;
  int         n_ack = 0;
  int         en_cyc = 0;
  logic [N-1:0] en_owner;
  bit         tmo_seen;
  int         tmo_cyc;
  logic [N-1:0] tmo_grant;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] gidx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return 3'(i);
    return 3'd7;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rhead[i] < rtail[i]) begin
        req[i]       = 1'b1;
        last[i]      = rbuf[i][rhead[i]][8];
        data[8*i+:8] = rbuf[i][rhead[i]][7:0];
      end else begin
        req[i]       = 1'b0;
        last[i]      = 1'b0;
        data[8*i+:8] = 8'h00;
      end
    end
  endtask

  task automatic add(input int i, input logic [7:0] b, input logic l);
    rbuf[i][rtail[i]] = {l, b};
    rtail[i]++;
    mp[i][mlen[i]] = {l, b};
    mlen[i]++;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) mlen[i] = 0;
    expq.delete();
  endtask

  // Packet-level schedule: each grant sends bytes until 'last' or MB bytes,
  // then the pointer moves past the owner.
  task automatic build();
    int h [N];
    int own, cnt;
    logic lst;
    for (int i = 0; i < N; i++) h[i] = 0;
    forever begin
      own = -1;
      for (int k = 0; k < N; k++)
        if (own < 0 && h[(model_ptr + k) % N] < mlen[(model_ptr + k) % N])
          own = (model_ptr + k) % N;
      if (own < 0) break;
      cnt = 0;
      do begin
        expq.push_back({3'(own), mp[own][h[own]][7:0]});
        lst = mp[own][h[own]][8];
        h[own]++;
        cnt++;
      end while (!lst && !(MB != 0 && cnt == MB) && h[own] < mlen[own]);
      model_ptr = (own + 1) % N;
    end
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (rhead[i] < rtail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_reset_vals();
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; end
    drive();
    sb_on = 1'b0;
    expq.delete();
    umode = 0; ucnt = 0; tx_rdy = 1'b1;
    model_ptr = 0;
    tmo_seen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(posedge clk); #1;
      done = queues_empty() && !busy && tx_rdy && expq.size() == 0;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s: not idle after %0d cycles, %0d bytes still expected", tag, budget, expq.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // requester side: consume the head byte the cycle after its ack
  initial begin
    forever begin
      @(negedge clk);
      pp = ack;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (pp[i] && rhead[i] < rtail[i]) rhead[i]++;
      drive();
    end
  end

  // uart_tx model: rdy falls the cycle after en, low for 10 cycles
  initial begin
    forever begin
      @(negedge clk);
      en_s = tx_en;
      @(posedge clk); #1;
      case (umode)
        1: tx_rdy = 1'b1;
        2: tx_rdy = 1'b0;
        default: begin
          if (ucnt > 0) begin
            ucnt--;
            if (ucnt == 0) tx_rdy = 1'b1;
          end else if (en_s && tx_rdy) begin
            tx_rdy = 1'b0;
            ucnt   = 10;
          end else begin
            tx_rdy = 1'b1;
          end
        end
      endcase
    end
  end

  // per-cycle compare against rules and the predicted byte order
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        chk("ack_vs_en", ack, tx_en ? grant : '0);
        chk("grant_onehot0", 32'($onehot0(grant)), 1);
        chk("busy_vs_grant", busy, |grant);
        if (tx_en) begin
          chk("en_needs_rdy", tx_rdy, 1);
          n_en++;
          en_cyc   = cyc;
          en_owner = grant;
          if (sb_on) begin
            if (expq.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL tx_order: got byte %0h from grant %b, expected none", tx_data, grant);
            end else begin
              e = expq.pop_front();
              chk("tx_order", {gidx(grant), tx_data}, e);
            end
          end
        end else begin
          chk("tx_data_hold", tx_data, prev_data);
        end
        n_ack += $countones(ack);
        if (timeout_err && !tmo_seen) begin
          tmo_seen  = 1'b1;
          tmo_cyc   = cyc;
          tmo_grant = grant;
        end
      end
      prev_data = tx_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n0, a0;
    bit seen;
    logic [10:0] lit [6];
    rst = 1'b1; req = '0; last = '0; data = '0; tx_rdy = 1'b1;
    umode = 0; ucnt = 0; sb_on = 1'b0; tmo_seen = 1'b0;
    for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; mlen[i] = 0; end

    // single 3-byte packet from requester 0
    do_reset();
    model_clear();
    add(0, 8'h41, 1'b0); add(0, 8'h42, 1'b0); add(0, 8'h43, 1'b1);
    build();
    chk("s1_model_len", expq.size(), 3);
    chk("s1_model_0", expq[0], {3'd0, 8'h41});
    chk("s1_model_2", expq[2], {3'd0, 8'h43});
    n0 = n_en; a0 = n_ack;
    sb_on = 1'b1;
    drive();
    wait_done(400, "s1_done");
    chk("s1_en_count", n_en - n0, 3);
    chk("s1_ack_count", n_ack - a0, 3);
    chk("s1_grant_idle", grant, 0);
    chk("s1_no_tmo", timeout_err, 0);

    // requesters 1 and 2 together; then 0 and 3 show the pointer at 3
    do_reset();
    model_clear();
    add(1, 8'h11, 1'b0); add(1, 8'h12, 1'b1);
    add(2, 8'h21, 1'b0); add(2, 8'h22, 1'b1);
    build();
    chk("s2_model_0", expq[0], {3'd1, 8'h11});
    chk("s2_model_2", expq[2], {3'd2, 8'h21});
    sb_on = 1'b1;
    drive();
    wait_done(400, "s2_done");
    chk("s2_model_ptr", model_ptr, 3);
    model_clear();
    add(0, 8'h01, 1'b1); add(3, 8'h31, 1'b1);
    build();
    chk("s2_model_next", expq[0], {3'd3, 8'h31});
    drive();
    wait_done(400, "s2_ptr_done");

    // burst cap of 2 lets requester 3 in mid-packet
    do_reset();
    model_clear();
    add(0, 8'hA0, 1'b0); add(0, 8'hA1, 1'b0); add(0, 8'hA2, 1'b0);
    add(0, 8'hA3, 1'b0); add(0, 8'hA4, 1'b1);
    add(3, 8'hD0, 1'b1);
    build();
    lit[0] = {3'd0, 8'hA0}; lit[1] = {3'd0, 8'hA1}; lit[2] = {3'd3, 8'hD0};
    lit[3] = {3'd0, 8'hA2}; lit[4] = {3'd0, 8'hA3}; lit[5] = {3'd0, 8'hA4};
    chk("s3_model_len", expq.size(), 6);
    for (int k = 0; k < 6; k++) chk("s3_model_order", expq[k], lit[k]);
    sb_on = 1'b1;
    drive();
    wait_done(800, "s3_done");
    chk("s3_no_tmo", timeout_err, 0);

    // rdy stuck high after en
    do_reset();
    umode = 1;
    model_clear();
    add(0, 8'h55, 1'b1);
    build();
    sb_on = 1'b1;
    n0 = n_en;
    drive();
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(posedge clk); #1; seen = tmo_seen; end
    chk("s4_tmo_seen", seen, 1);
    chk("s4_tmo_delay", tmo_cyc - en_cyc, TO);
    chk("s4_tmo_grant", tmo_grant, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("s4_single_en", n_en - n0, 1);
    chk("s4_sticky", timeout_err, 1);
    chk("s4_idle", busy, 0);

    // reset while holding a byte of requester 2's packet
    do_reset();
    model_clear();
    add(1, 8'h71, 1'b1);
    build();
    sb_on = 1'b1;
    drive();
    wait_done(400, "s5_pre_done");
    sb_on = 1'b0;
    add(2, 8'h81, 1'b0); add(2, 8'h82, 1'b0); add(2, 8'h83, 1'b1);
    drive();
    n0 = n_en;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin @(posedge clk); #1; seen = (n_en > n0); end
    chk("s5_en_seen", seen, 1);
    chk("s5_first_owner", en_owner, 4'b0100);
    rst = 1'b1;
    add(0, 8'h91, 1'b1);
    drive();
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;
    expq.delete();
    expq.push_back({3'd0, 8'h91});
    expq.push_back({3'd2, 8'h82});
    expq.push_back({3'd2, 8'h83});
    sb_on = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin @(posedge clk); #1; seen = (grant != 0); end
    chk("s5_post_rst_grant", grant, 4'b0001);
    wait_done(600, "s5_done");

    // requester 2 withdraws while waiting for rdy
    do_reset();
    umode = 2;
    tx_rdy = 1'b0;
    model_clear();
    sb_on = 1'b1;
    n0 = n_en; a0 = n_ack;
    add(2, 8'hA5, 1'b1);
    drive();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin @(posedge clk); #1; seen = (grant != 0); end
    chk("s6_grant", grant, 4'b0100);
    repeat (4) @(posedge clk);
    #1;
    chk("s6_busy", busy, 1);
    rhead[2] = rtail[2];
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("s6_released", grant, 0);
    chk("s6_idle", busy, 0);
    chk("s6_no_en", n_en - n0, 0);
    chk("s6_no_ack", n_ack - a0, 0);
    umode = 0; ucnt = 0; tx_rdy = 1'b1;
    model_clear();
    model_ptr = 3;
    add(0, 8'h0A, 1'b1); add(3, 8'h3A, 1'b1);
    build();
    chk("s6_model_next", expq[0], {3'd3, 8'h3A});
    drive();
    wait_done(400, "s6_done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
